// File: rtl/sensor_conditioner_if.sv
// Loop-detector conditioning bus: raw detector levels and fault clear in,
// conditioned presence and stuck flags out. Lanes are indexed [8:1].
interface sensor_conditioner_if;
    localparam int unsigned NUM_LANES = 8;

    logic [NUM_LANES:1] raw_sensors;
    logic               clear_fault;
    logic [NUM_LANES:1] sensors;
    logic [NUM_LANES:1] stuck;
    logic               fault;

    modport master (
        output raw_sensors,
        output clear_fault,
        input  sensors,
        input  stuck,
        input  fault
    );

    modport slave (
        input  raw_sensors,
        input  clear_fault,
        output sensors,
        output stuck,
        output fault
    );
endinterface

// File: rtl/sensor_conditioner.sv
// Per-lane loop-detector conditioner: 2-flop synchroniser, debounce and
// hold-extend FSM per lane, feeding the controller's sensors[8:1] bus.
// Optional stuck-on detection/masking is compiled in with
// `define SENSOR_STUCK_DETECT_EN; without it stuck/fault are tied low.
module sensor_conditioner #(
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned HOLD        = 3,
    parameter int unsigned STUCK_LIMIT = 600
) (
    input  logic                 clk,
    input  logic                 rst,
    sensor_conditioner_if.slave  bus
);
    localparam int unsigned NUM_LANES = 8;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned STUCK_W   = 12;

    localparam logic [CNT_W-1:0]   DEB_LAST  = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD - 1);
    localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        PRESENT = 2'd2,
        HOLDOFF = 2'd3
    } lane_state_e;

    logic [NUM_LANES:1] sync1_q;
    logic [NUM_LANES:1] sync2_q;
    lane_state_e        state_q [NUM_LANES:1];
    lane_state_e        state_d [NUM_LANES:1];
    logic [CNT_W-1:0]   cnt_q   [NUM_LANES:1];
    logic [CNT_W-1:0]   cnt_d   [NUM_LANES:1];
    logic [NUM_LANES:1] sensors_q;
    logic [NUM_LANES:1] sensors_d;
    logic [NUM_LANES:1] lane_mask;

    // Two-flop synchroniser; the second flop is the FSM sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.raw_sensors;
            sync2_q <= sync1_q;
        end
    end

`ifdef SENSOR_STUCK_DETECT_EN
    logic [STUCK_W-1:0] run_q [NUM_LANES:1];
    logic [STUCK_W-1:0] run_d [NUM_LANES:1];
    logic [NUM_LANES:1] stuck_q;
    logic [NUM_LANES:1] stuck_d;
    logic [NUM_LANES:1] stuck_set;
    logic               fault_q;

    // Saturating high-run counters; clear wins over a same-edge set.
    always_comb begin
        run_d     = run_q;
        stuck_d   = stuck_q;
        stuck_set = '0;
        for (int i = 1; i <= int'(NUM_LANES); i++) begin
            if (bus.clear_fault) begin
                run_d[i]   = '0;
                stuck_d[i] = 1'b0;
            end else if (!sync2_q[i]) begin
                run_d[i] = '0;
            end else begin
                if (run_q[i] != STUCK_MAX) begin
                    run_d[i] = run_q[i] + STUCK_W'(1);
                end
                if (run_d[i] == STUCK_MAX) begin
                    stuck_set[i] = 1'b1;
                    stuck_d[i]   = 1'b1;
                end
            end
        end
    end

    // Stuck state registers; fault is the registered OR of the flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i <= int'(NUM_LANES); i++) begin
                run_q[i] <= '0;
            end
            stuck_q <= '0;
            fault_q <= 1'b0;
        end else begin
            run_q   <= run_d;
            stuck_q <= stuck_d;
            fault_q <= |stuck_d;
        end
    end

    // A stuck lane (including the edge it is declared) is held in IDLE.
    assign lane_mask = stuck_q | stuck_set;
    assign bus.stuck = stuck_q;
    assign bus.fault = fault_q;
`else
    logic unused_stuck_inputs;

    // Detection compiled out: nothing is masked and the flags tie low.
    assign lane_mask           = '0;
    assign bus.stuck           = '0;
    assign bus.fault           = 1'b0;
    assign unused_stuck_inputs = ^{bus.clear_fault, STUCK_MAX};
`endif

    // Per-lane debounce/hold next-state logic and presence decode.
    always_comb begin
        for (int i = 1; i <= int'(NUM_LANES); i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            sensors_d[i] = 1'b0;
            if (lane_mask[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (sync2_q[i]) begin
                            if (DEBOUNCE == 1) begin
                                state_d[i] = PRESENT;
                            end else begin
                                state_d[i] = ARM;
                                cnt_d[i]   = CNT_W'(1);
                            end
                        end
                    end
                    ARM: begin
                        if (!sync2_q[i]) begin
                            state_d[i] = IDLE;
                        end else if (cnt_q[i] == DEB_LAST) begin
                            state_d[i] = PRESENT;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    PRESENT: begin
                        if (!sync2_q[i]) begin
                            if (HOLD == 1) begin
                                state_d[i] = IDLE;
                            end else begin
                                state_d[i] = HOLDOFF;
                                cnt_d[i]   = CNT_W'(1);
                            end
                        end
                    end
                    HOLDOFF: begin
                        if (sync2_q[i]) begin
                            state_d[i] = PRESENT;
                        end else if (cnt_q[i] == HOLD_LAST) begin
                            state_d[i] = IDLE;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            sensors_d[i] = (state_d[i] == PRESENT) || (state_d[i] == HOLDOFF);
        end
    end

    // Lane state registers; presence is registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i <= int'(NUM_LANES); i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            sensors_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sensors_q <= sensors_d;
        end
    end

    assign bus.sensors = sensors_q;
endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: stimulus pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_sensor_conditioner;
    localparam int DEB = 4;
    localparam int HLD = 3;
    localparam int LIM = 20;
`ifdef SENSOR_STUCK_DETECT_EN
    localparam bit STUCK_EN = 1'b1;
`else
    localparam bit STUCK_EN = 1'b0;
`endif

    typedef struct {
        logic [8:1] sensors;
        logic [8:1] stuck;
        logic       fault;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic rst;

    // Reference model state for the free-running phase.
    logic [8:1] m_s1;
    logic [8:1] m_s2;
    logic [8:1] m_pres;
    int         m_hi [8:1];
    int         m_lo [8:1];

    sensor_conditioner_if bus ();

    sensor_conditioner #(
        .DEBOUNCE   (DEB),
        .HOLD       (HLD),
        .STUCK_LIMIT(LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input logic [8:1] es, input logic [8:1] est, input string tag);
        exp_t e;
        e.sensors = es;
        e.stuck   = est;
        e.fault   = |est;
        e.tag     = tag;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs, then queue what must be visible after the edge.
    task automatic step(input logic [8:1] raw, input logic clr,
                        input logic [8:1] es, input logic [8:1] est, input string tag);
        @(negedge clk);
        bus.raw_sensors = raw;
        bus.clear_fault = clr;
        @(posedge clk);
        #1;
        push_exp(es, est, tag);
    endtask

    // Assert reset mid-cycle; outputs must clear before the next edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        @(posedge clk);
        #3;
        rst             = 1'b0;
        bus.raw_sensors = '0;
        bus.clear_fault = 1'b0;
        #1;
        push_exp('0, '0, tag);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic model_reset();
        m_s1   = '0;
        m_s2   = '0;
        m_pres = '0;
        for (int i = 1; i <= 8; i++) begin
            m_hi[i] = 0;
            m_lo[i] = 0;
        end
    endtask

    // Run-length model: presence after DEB highs, dropped after HLD lows.
    task automatic model_edge(input logic [8:1] raw);
        for (int i = 1; i <= 8; i++) begin
            if (m_s2[i]) begin
                m_lo[i] = 0;
                if (m_hi[i] < 15) m_hi[i]++;
                if (!m_pres[i] && m_hi[i] >= DEB) m_pres[i] = 1'b1;
            end else begin
                m_hi[i] = 0;
                if (m_lo[i] < 15) m_lo[i]++;
                if (m_pres[i] && m_lo[i] >= HLD) m_pres[i] = 1'b0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    // Monitor: every queued expectation is compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.sensors !== e.sensors || bus.stuck !== e.stuck || bus.fault !== e.fault) begin
                    errors++;
                    $display("FAIL %s: got sensors=%h stuck=%h fault=%b, want sensors=%h stuck=%h fault=%b",
                             e.tag, bus.sensors, bus.stuck, bus.fault, e.sensors, e.stuck, e.fault);
                end
            end
        end
    end

    initial begin
        logic [8:1] raw;
        logic [8:1] es;
        logic [8:1] est;

        rst             = 1'b0;
        bus.raw_sensors = '0;
        bus.clear_fault = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push_exp('0, '0, "reset_state");
        @(negedge clk);
        rst = 1'b1;

        // Lane 1 held high: presence after edge DEB+1.
        for (int e = 0; e < 8; e++) begin
            step(8'h01, 1'b0, (e >= 5) ? 8'h01 : 8'h00, 8'h00, "t1_rise");
        end
        do_reset("t1_rst");

        // Lane 3: 3 highs, 1 low, then a full burst.
        for (int e = 0; e < 11; e++) begin
            raw = (e == 3) ? 8'h00 : 8'h04;
            step(raw, 1'b0, (e >= 9) ? 8'h04 : 8'h00, 8'h00, "t2_debounce");
        end
        do_reset("t2_rst");

        // Lane 5: short gap survives, a HOLD-long gap drops presence.
        for (int e = 0; e < 18; e++) begin
            raw = (e <= 5 || (e >= 8 && e <= 10)) ? 8'h10 : 8'h00;
            step(raw, 1'b0, (e >= 5 && e <= 14) ? 8'h10 : 8'h00, 8'h00, "t3_hold");
        end
        do_reset("t3_rst");

`ifdef SENSOR_STUCK_DETECT_EN
        // Lane 7 stuck at high sample LIM, cleared, then re-debounced.
        for (int e = 0; e < 25; e++) begin
            step(8'h40, 1'b0, (e >= 5 && e <= 20) ? 8'h40 : 8'h00,
                 (e >= 21) ? 8'h40 : 8'h00, "t4_stuck");
        end
        step(8'h40, 1'b1, 8'h00, 8'h00, "t4_clear");
        for (int e = 26; e < 32; e++) begin
            step(8'h40, 1'b0, (e >= 29) ? 8'h40 : 8'h00, 8'h00, "t4_rearm");
        end
        do_reset("t4_rst");
`endif

        // Lane 7 long high, lane 2 into HOLDOFF, lane 1 in ARM, then reset.
        for (int e = 0; e < 22; e++) begin
            raw = 8'h40;
            if (e >= 12 && e <= 17) raw = raw | 8'h02;
            if (e >= 19) raw = raw | 8'h01;
            es = '0;
            if (STUCK_EN ? (e >= 5 && e <= 20) : (e >= 5)) es = es | 8'h40;
            if (e >= 17) es = es | 8'h02;
            est = (STUCK_EN && e >= 21) ? 8'h40 : 8'h00;
            step(raw, 1'b0, es, est, "t5_setup");
        end
        do_reset("t5_rst_async");
        for (int e = 0; e < 4; e++) begin
            step(8'h00, 1'b0, 8'h00, 8'h00, "t5_post_rst");
        end

        // All lanes toggling with independent patterns against the model.
        model_reset();
        for (int c = 0; c < 150; c++) begin
            for (int i = 1; i <= 8; i++) begin
                int p;
                int h;
                p = 2 * i + 2 + (i % 3);
                h = i + 1 + ((c / 37) % 2);
                raw[i] = ((c + 3 * i) % p) < h;
            end
            model_edge(raw);
            step(raw, 1'b0, m_pres, 8'h00, "t6_lanes");
        end

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
